audio_i2s_tx: RTL and testbench

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

---
 rtl/audio_i2s_tx.sv | 117 +++++++++++
 tb/tb_audio_i2s_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// Mono I2S transmitter: one 24-bit sample per frame, sent in both slots,
// with a one-deep holding buffer and sticky overrun/underrun flags.
module audio_i2s_tx #(
  parameter int unsigned HALF_BCLK = 4,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] i_data,
  input  logic        i_valid,
  input  logic        i_clr_flags,
  output logic        o_bclk,
  output logic        o_lrclk,
  output logic        o_sdata,
  output logic        o_overrun,
  output logic        o_underrun
);

  localparam int unsigned DivW      = (HALF_BCLK > 1) ? $clog2(HALF_BCLK) : 1;
  localparam int unsigned FrameBits = 2 * SLOT_BITS;
  localparam int unsigned IdxW      = $clog2(FrameBits);

  logic [DivW-1:0] div_cnt;
  logic [IdxW-1:0] bit_idx, bit_idx_d;
  logic            started;
  logic [23:0]     hold_reg, hold_reg_d;
  logic [23:0]     frame_word, frame_word_d;
  logic            hold_full, hold_full_d;
  logic            div_wrap, fall_ev, frame_start;
  logic            lrclk_d, sdata_d;
  logic [IdxW-1:0] slot_k;
  logic [4:0]      bit_sel;
  logic            overrun_set, underrun_set;

  assign div_wrap = (div_cnt == DivW'(HALF_BCLK - 1));
  assign fall_ev  = div_wrap & o_bclk;

  // The first fall after reset keeps bit_idx at 0 so that it starts a frame.
  always_comb begin
    bit_idx_d = bit_idx;
    if (fall_ev && started) begin
      bit_idx_d = (bit_idx == IdxW'(FrameBits - 1)) ? '0 : bit_idx + IdxW'(1);
    end
  end

  assign frame_start = fall_ev & (bit_idx_d == '0);

  always_comb begin
    lrclk_d = (bit_idx_d >= IdxW'(SLOT_BITS));
    slot_k  = lrclk_d ? bit_idx_d - IdxW'(SLOT_BITS) : bit_idx_d;
    bit_sel = 5'(IdxW'(24) - slot_k);
    sdata_d = 1'b0;
    if (slot_k >= IdxW'(1) && slot_k <= IdxW'(24)) begin
      sdata_d = frame_word[bit_sel];
    end
  end

  always_comb begin
    frame_word_d = frame_word;
    hold_reg_d   = hold_reg;
    hold_full_d  = hold_full;
    overrun_set  = 1'b0;
    underrun_set = 1'b0;
    if (frame_start) begin
      if (hold_full) begin
        frame_word_d = hold_reg;
        if (i_valid) begin
          hold_reg_d = i_data;
        end else begin
          hold_full_d = 1'b0;
        end
      end else if (i_valid) begin
        frame_word_d = i_data;
      end else begin
        underrun_set = 1'b1;
      end
    end else if (i_valid) begin
      hold_reg_d  = i_data;
      hold_full_d = 1'b1;
      overrun_set = hold_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      bit_idx    <= '0;
      started    <= 1'b0;
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      frame_word <= '0;
      o_bclk     <= 1'b0;
      o_lrclk    <= 1'b0;
      o_sdata    <= 1'b0;
      o_overrun  <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DivW'(1);
      if (div_wrap) begin
        o_bclk <= ~o_bclk;
      end
      if (fall_ev) begin
        started <= 1'b1;
        o_lrclk <= lrclk_d;
        o_sdata <= sdata_d;
      end
      bit_idx    <= bit_idx_d;
      hold_reg   <= hold_reg_d;
      hold_full  <= hold_full_d;
      frame_word <= frame_word_d;
      // A set event in the same cycle as a clear wins.
      o_overrun  <= overrun_set | (o_overrun & ~i_clr_flags);
      o_underrun <= underrun_set | (o_underrun & ~i_clr_flags);
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: directed frame scenarios plus a random run checked
// against a cycle-count based reference model of the I2S stream.
module tb_audio_i2s_tx;

  localparam int H  = 4;
  localparam int S  = 32;
  localparam int FB = 2 * S;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_clr_flags = 1'b0;
  logic        o_bclk, o_lrclk, o_sdata, o_overrun, o_underrun;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  audio_i2s_tx #(.HALF_BCLK(H), .SLOT_BITS(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_clr_flags(i_clr_flags),
    .o_bclk     (o_bclk),
    .o_lrclk    (o_lrclk),
    .o_sdata    (o_sdata),
    .o_overrun  (o_overrun),
    .o_underrun (o_underrun)
  );

  // Reference model: everything is derived from the number of clock edges
  // since reset release. Edge e is a fall event when e is a multiple of 2*H;
  // fall number m = e/(2*H) carries frame bit (m-1) mod 2*S.
  int          m_edges;
  bit          m_fall;
  int          m_idx;
  bit          m_pend;
  logic [23:0] m_pval, m_word;
  bit          m_over, m_under;
  logic        e_bclk, e_lr, e_sd;

  always @(posedge clk or negedge rst_n) begin
    int e, k;
    bit fs, oset, uset;
    if (!rst_n) begin
      m_edges = 0; m_fall = 0; m_idx = 0; m_pend = 0; m_pval = '0; m_word = '0;
      m_over = 0; m_under = 0; e_bclk = 0; e_lr = 0; e_sd = 0;
    end else begin
      m_edges++;
      e = m_edges;
      m_fall = (e % (2 * H) == 0);
      fs = 0; oset = 0; uset = 0;
      if (m_fall) begin
        m_idx = (e / (2 * H) - 1) % FB;
        fs = (m_idx == 0);
      end
      if (fs) begin
        if (m_pend) begin
          m_word = m_pval;
          if (i_valid) m_pval = i_data;
          else m_pend = 0;
        end else if (i_valid) begin
          m_word = i_data;
        end else begin
          uset = 1;
        end
      end else if (i_valid) begin
        oset = m_pend;
        m_pval = i_data;
        m_pend = 1;
      end
      if (i_clr_flags) begin m_over = 0; m_under = 0; end
      if (oset) m_over = 1;
      if (uset) m_under = 1;
      e_bclk = ((e / H) % 2) == 1;
      if (m_fall) begin
        k = m_idx % S;
        e_lr = (m_idx >= S);
        e_sd = (k >= 1 && k <= 24) ? m_word[24-k] : 1'b0;
      end
    end
  end

  function automatic bit fs_next();
    int e;
    e = m_edges + 1;
    return (e % (2 * H) == 0) && (((e / (2 * H)) - 1) % FB == 0);
  endfunction

  function automatic logic [FB-1:0] frame_of(input logic [23:0] w);
    return {1'b0, w, 7'b0, 1'b0, w, 7'b0};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_clr_flags = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_valid(input logic [23:0] d);
    i_data = d; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // Records one whole frame, optionally strobing i_valid / i_clr_flags on the
  // frame-start cycle itself.
  task automatic capture_frame(input bit inj_v, input logic [23:0] inj_d, input bit inj_clr,
                               output logic [FB-1:0] sd, output logic [FB-1:0] lr,
                               output bit ok);
    bit found = 0;
    int n = 0;
    sd = '0; lr = '0;
    for (int c = 0; c < 5000 && !found; c++) begin
      if (fs_next()) found = 1;
      else begin
        @(negedge clk);
        i_valid = 1'b0; i_clr_flags = 1'b0;
      end
    end
    if (found) begin
      i_valid = inj_v;
      if (inj_v) i_data = inj_d;
      i_clr_flags = inj_clr;
      for (int c = 0; c < 5000 && n < FB; c++) begin
        @(negedge clk);
        i_valid = 1'b0; i_clr_flags = 1'b0;
        if (m_fall) begin
          sd[FB-1-m_idx] = o_sdata;
          lr[FB-1-m_idx] = o_lrclk;
          n++;
        end
      end
    end
    ok = found && (n == FB);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (o_bclk !== 1'b0) begin bad++; $display("FAIL reset_bclk got=%b want=0", o_bclk); end
    total++; if (o_lrclk !== 1'b0) begin bad++; $display("FAIL reset_lrclk got=%b want=0", o_lrclk); end
    total++; if (o_sdata !== 1'b0) begin bad++; $display("FAIL reset_sdata got=%b want=0", o_sdata); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", o_overrun); end
    total++; if (o_underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", o_underrun); end
  endtask

  task automatic test_frame_pattern();
    logic [FB-1:0] sd, lr;
    bit ok;
    do_reset();
    pulse_valid(24'h800001);
    capture_frame(0, '0, 0, sd, lr, ok);
    total++; if (!ok) begin bad++; $display("FAIL pattern_timeout got=0 want=1"); end
    total++; if (sd !== frame_of(24'h800001)) begin
      bad++; $display("FAIL pattern_sdata got=%h want=%h", sd, frame_of(24'h800001)); end
    total++; if (lr !== {32'h0, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL pattern_lrclk got=%h want=%h", lr, {32'h0, 32'hFFFF_FFFF}); end
    total++; if (o_underrun !== 1'b0) begin bad++; $display("FAIL pattern_underrun got=%b want=0", o_underrun); end
  endtask

  task automatic test_underrun_repeat();
    logic [FB-1:0] sd, lr;
    bit ok;
    do_reset();
    pulse_valid(24'h123456);
    capture_frame(0, '0, 0, sd, lr, ok);
    total++; if (sd !== frame_of(24'h123456)) begin
      bad++; $display("FAIL repeat_first got=%h want=%h", sd, frame_of(24'h123456)); end
    total++; if (o_underrun !== 1'b0) begin bad++; $display("FAIL repeat_under0 got=%b want=0", o_underrun); end
    capture_frame(0, '0, 0, sd, lr, ok);
    total++; if (!ok || sd !== frame_of(24'h123456)) begin
      bad++; $display("FAIL repeat_second got=%h want=%h", sd, frame_of(24'h123456)); end
    total++; if (o_underrun !== 1'b1) begin bad++; $display("FAIL repeat_under1 got=%b want=1", o_underrun); end
  endtask

  task automatic test_overrun();
    logic [FB-1:0] sd, lr;
    bit ok;
    do_reset();
    pulse_valid(24'h000010);
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL overrun_early got=%b want=0", o_overrun); end
    pulse_valid(24'h000020);
    total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%b want=1", o_overrun); end
    capture_frame(0, '0, 0, sd, lr, ok);
    total++; if (!ok || sd !== frame_of(24'h000020)) begin
      bad++; $display("FAIL overrun_data got=%h want=%h", sd, frame_of(24'h000020)); end
  endtask

  task automatic test_bypass();
    logic [FB-1:0] sd, lr;
    bit ok;
    do_reset();
    capture_frame(1, 24'h7FFFFF, 0, sd, lr, ok);
    total++; if (!ok || sd !== frame_of(24'h7FFFFF)) begin
      bad++; $display("FAIL bypass_data got=%h want=%h", sd, frame_of(24'h7FFFFF)); end
    total++; if (o_underrun !== 1'b0) begin bad++; $display("FAIL bypass_underrun got=%b want=0", o_underrun); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL bypass_overrun got=%b want=0", o_overrun); end
  endtask

  task automatic test_clr_coincide();
    logic [FB-1:0] sd, lr;
    bit ok;
    do_reset();
    capture_frame(0, '0, 0, sd, lr, ok);
    total++; if (!ok || sd !== '0) begin bad++; $display("FAIL clr_zero_frame got=%h want=0", sd); end
    total++; if (o_underrun !== 1'b1) begin bad++; $display("FAIL clr_under_set got=%b want=1", o_underrun); end
    capture_frame(0, '0, 1, sd, lr, ok);
    total++; if (o_underrun !== 1'b1) begin bad++; $display("FAIL clr_set_wins got=%b want=1", o_underrun); end
    i_clr_flags = 1'b1;
    @(negedge clk);
    i_clr_flags = 1'b0;
    total++; if (o_underrun !== 1'b0) begin bad++; $display("FAIL clr_alone got=%b want=0", o_underrun); end
  endtask

  task automatic test_reset_midframe();
    logic [FB-1:0] sd, lr;
    bit ok;
    logic exp_b;
    do_reset();
    pulse_valid(24'hABCDEF);
    repeat (100) @(negedge clk);
    pulse_valid(24'h55AA55);
    repeat (37) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({o_bclk, o_lrclk, o_sdata, o_overrun, o_underrun} !== 5'b0) begin
      bad++; $display("FAIL midreset_async got=%b want=00000",
                      {o_bclk, o_lrclk, o_sdata, o_overrun, o_underrun}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_b = (k >= 4 && k < 8);
      total++; if (o_bclk !== exp_b) begin
        bad++; $display("FAIL midreset_bclk k=%0d got=%b want=%b", k, o_bclk, exp_b); end
    end
    total++; if (o_lrclk !== 1'b0) begin bad++; $display("FAIL midreset_lrclk got=%b want=0", o_lrclk); end
    capture_frame(0, '0, 0, sd, lr, ok);
    total++; if (!ok || sd !== '0) begin bad++; $display("FAIL midreset_discard got=%h want=0", sd); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      total++; if (o_bclk !== e_bclk) begin
        bad++; $display("FAIL rand_bclk cyc=%0d got=%b want=%b", c, o_bclk, e_bclk); end
      total++; if (o_lrclk !== e_lr) begin
        bad++; $display("FAIL rand_lrclk cyc=%0d got=%b want=%b", c, o_lrclk, e_lr); end
      total++; if (o_sdata !== e_sd) begin
        bad++; $display("FAIL rand_sdata cyc=%0d got=%b want=%b", c, o_sdata, e_sd); end
      total++; if (o_overrun !== m_over) begin
        bad++; $display("FAIL rand_overrun cyc=%0d got=%b want=%b", c, o_overrun, m_over); end
      total++; if (o_underrun !== m_under) begin
        bad++; $display("FAIL rand_underrun cyc=%0d got=%b want=%b", c, o_underrun, m_under); end
      i_data      = 24'($urandom);
      i_valid     = ($urandom_range(0, 299) == 0);
      i_clr_flags = ($urandom_range(0, 249) == 0);
    end
    i_valid = 1'b0;
    i_clr_flags = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_pattern();
    test_underrun_repeat();
    test_overrun();
    test_bypass();
    test_clr_coincide();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
